// File: rtl/message_checker.sv
// message_checker: sink for length-prefixed messages; checks payload against (seq+k) and keeps saturating error stats.
module message_checker #(
  parameter int MAX_LEN   = 200,
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [7:0]           message,
  input  logic                 messageValid,
  input  logic                 clearCounts,
  output logic                 msgDone,
  output logic                 msgOk,
  output logic                 error,
  output logic [7:0]           expectedSeq,
  output logic [CNT_WIDTH-1:0] msgCount,
  output logic [CNT_WIDTH-1:0] byteErrCount,
  output logic [CNT_WIDTH-1:0] lenErrCount,
  output logic [CNT_WIDTH-1:0] timeoutCount
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  localparam logic [IW-1:0] T_LAST = IW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] rem_q, rem_d, cur_q, cur_d, seq_q, seq_d;
  logic [IW-1:0] idle_q, idle_d;
  logic bad_q, bad_d, done_q, done_d, ok_q, ok_d, err_q, err_d;
  logic [CNT_WIDTH-1:0] msg_q, msg_d, berr_q, berr_d, lerr_q, lerr_d, tmo_q, tmo_d;
  logic fin, ok, tmo, len_err, byte_err;
  function automatic logic [CNT_WIDTH-1:0] sat(input logic [CNT_WIDTH-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    cur_d = cur_q;
    bad_d = bad_q;
    idle_d = idle_q;
    fin = 1'b0;
    ok = 1'b0;
    tmo = 1'b0;
    len_err = 1'b0;
    byte_err = 1'b0;
    if (state_q == IDLE) begin
      idle_d = '0;
      if (messageValid) begin
        rem_d = message;
        cur_d = seq_q;
        bad_d = 1'b0;
        len_err = (message == 8'd0) || (message > MAX_L);
        state_d = (message == 8'd0) ? IDLE : (message > MAX_L) ? DRAIN : PAYLOAD;
      end
    end else if (messageValid) begin
      idle_d = '0;
      rem_d = rem_q - 8'd1;
      cur_d = cur_q + 8'd1;
      byte_err = (state_q == PAYLOAD) && (message != cur_q);
      bad_d = bad_q | byte_err;
      fin = (rem_q == 8'd1);
      ok = fin && (state_q == PAYLOAD) && !bad_d;
      state_d = fin ? IDLE : state_q;
    end else if (idle_q == T_LAST) begin
      fin = 1'b1;
      tmo = 1'b1;
      state_d = IDLE;
    end else begin
      idle_d = idle_q + 1'b1;
    end
    done_d = fin;
    ok_d = ok;
    seq_d = fin ? seq_q + 8'd1 : seq_q;
    // clearing the statistics takes priority over any increment on the same edge
    msg_d = clearCounts ? '0 : sat(msg_q, ok);
    berr_d = clearCounts ? '0 : sat(berr_q, byte_err);
    lerr_d = clearCounts ? '0 : sat(lerr_q, len_err);
    tmo_d = clearCounts ? '0 : sat(tmo_q, tmo);
    err_d = clearCounts ? 1'b0 : (err_q | len_err | byte_err | tmo);
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      rem_q <= '0;
      cur_q <= '0;
      seq_q <= '0;
      idle_q <= '0;
      bad_q <= 1'b0;
      done_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      msg_q <= '0;
      berr_q <= '0;
      lerr_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      cur_q <= cur_d;
      seq_q <= seq_d;
      idle_q <= idle_d;
      bad_q <= bad_d;
      done_q <= done_d;
      ok_q <= ok_d;
      err_q <= err_d;
      msg_q <= msg_d;
      berr_q <= berr_d;
      lerr_q <= lerr_d;
      tmo_q <= tmo_d;
    end
  end
  assign msgDone = done_q;
  assign msgOk = ok_q;
  assign error = err_q;
  assign expectedSeq = seq_q;
  assign msgCount = msg_q;
  assign byteErrCount = berr_q;
  assign lenErrCount = lerr_q;
  assign timeoutCount = tmo_q;
endmodule
